mmp_iddmm_feeder: RTL and testbench

- Job controller that sits directly upstream of mmp_iddmm_sp.
- Accepts one job: a start command plus N parallel operand beats (x, y, m words, LSW first). Writes the beats into the multiplier's operand RAMs through its wr_* port and raises task_req.
- Captures the N result words the multiplier returns on task_grant/task_res into an N-deep buffer, then replays them on a valid/ready output stream.
- The output stream provides backpressure that mmp_iddmm_sp itself lacks.

---
 rtl/mmp_iddmm_feeder.sv | 195 +++++++++++++++++++
 tb/tb_mmp_iddmm_feeder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmp_iddmm_feeder.sv
// Job controller in front of mmp_iddmm_sp: loads operand RAMs, issues the task,
// buffers the N result words and replays them on a backpressured stream.
module mmp_iddmm_feeder #(
    parameter  int unsigned K  = 128,
    parameter  int unsigned N  = 32,
    localparam int unsigned AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    job_mask,
    input  logic [K-1:0]  cfg_m1,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [K-1:0]  in_x,
    input  logic [K-1:0]  in_y,
    input  logic [K-1:0]  in_m,
    output logic [2:0]    wr_ena,
    output logic [AW-1:0] wr_addr,
    output logic [K-1:0]  wr_x,
    output logic [K-1:0]  wr_y,
    output logic [K-1:0]  wr_m,
    output logic [K-1:0]  wr_m1,
    output logic          task_req,
    input  logic          task_end,
    input  logic          task_grant,
    input  logic [K-1:0]  task_res,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err_short,
    output logic          err_over
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LEND,
        S_REQ,
        S_WAIT
    } state_t;

    state_t          r_state;
    logic [2:0]      r_mask;
    logic [AW-1:0]   r_beat;
    logic [2:0]      r_wr_ena;
    logic [AW-1:0]   r_wr_addr;
    logic [K-1:0]    r_wr_x, r_wr_y, r_wr_m, r_wr_m1;
    logic            r_task_req, r_busy, r_done, r_err_short, r_err_over;

    logic [K-1:0]    r_mem [N];
    logic [AW-1:0]   r_wp, r_rp, r_ocnt;
    logic [CW-1:0]   r_cnt, r_gcnt;
    logic            r_out_valid, r_out_last;
    logic [K-1:0]    r_out_data;

    logic            w_start, w_pop, w_full, w_over, w_push;
    logic [CW-1:0]   w_cnt_pop, w_cnt_nxt, w_gcnt_nxt;
    logic [AW-1:0]   w_rp_nxt, w_ocnt_nxt;
    logic [K-1:0]    w_head_nxt;

    // A pop frees a slot in the same cycle, so push+pop on a full buffer is not an overflow.
    assign w_start    = (r_state == S_IDLE) && start;
    assign w_pop      = r_out_valid && out_ready;
    assign w_full     = (r_cnt == CW'(N));
    assign w_over     = task_grant && ((w_full && !w_pop) || (r_gcnt == CW'(N)));
    assign w_push     = task_grant && !w_over;
    assign w_cnt_pop  = r_cnt - CW'(w_pop);
    assign w_cnt_nxt  = w_cnt_pop + CW'(w_push);
    assign w_rp_nxt   = r_rp + AW'(w_pop);
    assign w_ocnt_nxt = r_ocnt + AW'(w_pop);
    assign w_head_nxt = (w_cnt_pop == '0) ? task_res : r_mem[w_rp_nxt];
    assign w_gcnt_nxt = w_start ? CW'(task_grant)
                      : (task_grant && (r_gcnt != CW'(N))) ? r_gcnt + CW'(1) : r_gcnt;

    // Result buffer with registered head/valid/last so the stream is driven from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_ocnt      <= '0;
            r_gcnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_err_over  <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= task_res;
                r_wp        <= r_wp + AW'(1);
            end
            r_rp        <= w_rp_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ocnt      <= w_ocnt_nxt;
            r_gcnt      <= w_gcnt_nxt;
            r_out_valid <= (w_cnt_nxt != '0);
            r_out_data  <= w_head_nxt;
            r_out_last  <= (w_cnt_nxt != '0) && (w_ocnt_nxt == AW'(N - 1));
            if (w_over) begin
                r_err_over <= 1'b1;
            end
        end
    end

    // Job sequencing: operand load, task request and completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_beat      <= '0;
            r_wr_ena    <= '0;
            r_wr_addr   <= '0;
            r_wr_x      <= '0;
            r_wr_y      <= '0;
            r_wr_m      <= '0;
            r_wr_m1     <= '0;
            r_task_req  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_short <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_wr_ena <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mask  <= job_mask;
                        r_wr_m1 <= cfg_m1;
                        r_beat  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (job_mask == 3'b000) ? S_REQ : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_wr_ena  <= r_mask;
                        r_wr_addr <= r_beat;
                        r_wr_x    <= in_x;
                        r_wr_y    <= in_y;
                        r_wr_m    <= in_m;
                        r_beat    <= r_beat + AW'(1);
                        if (r_beat == AW'(N - 1)) begin
                            r_state <= S_LEND;
                        end
                    end
                end
                S_LEND: r_state <= S_REQ;
                S_REQ: begin
                    if (r_cnt == '0) begin
                        r_task_req <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (task_end) begin
                        r_task_req <= 1'b0;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                        if (w_gcnt_nxt < CW'(N)) begin
                            r_err_short <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign wr_ena    = r_wr_ena;
    assign wr_addr   = r_wr_addr;
    assign wr_x      = r_wr_x;
    assign wr_y      = r_wr_y;
    assign wr_m      = r_wr_m;
    assign wr_m1     = r_wr_m1;
    assign task_req  = r_task_req;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_short = r_err_short;
    assign err_over  = r_err_over;

endmodule

// File: tb/tb_mmp_iddmm_feeder.sv
// Directed-sequence bench for mmp_iddmm_feeder with randomized data and a queue model.
module tb_mmp_iddmm_feeder;

    localparam int K  = 32;
    localparam int N  = 4;
    localparam int AW = 2;

    logic          clk, rst_n, start, in_valid, in_ready;
    logic [2:0]    job_mask, wr_ena;
    logic [K-1:0]  cfg_m1, in_x, in_y, in_m, wr_x, wr_y, wr_m, wr_m1, task_res, out_data;
    logic [AW-1:0] wr_addr;
    logic          task_req, task_end, task_grant, out_valid, out_ready, out_last;
    logic          busy, done, err_short, err_over;

    int checks   = 0;
    int failures = 0;
    int n_pops   = 0;
    logic [K-1:0] q[$];

    mmp_iddmm_feeder #(.K(K), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .job_mask(job_mask), .cfg_m1(cfg_m1),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_m(in_m),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m),
        .wr_m1(wr_m1), .task_req(task_req), .task_end(task_end), .task_grant(task_grant),
        .task_res(task_res), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
        .err_short(err_short), .err_over(err_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero();
        chk("rst_wr_ena", 64'(wr_ena), 0);    chk("rst_wr_addr", 64'(wr_addr), 0);
        chk("rst_wr_x", 64'(wr_x), 0);        chk("rst_wr_y", 64'(wr_y), 0);
        chk("rst_wr_m", 64'(wr_m), 0);        chk("rst_wr_m1", 64'(wr_m1), 0);
        chk("rst_task_req", 64'(task_req), 0); chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(out_data), 0); chk("rst_out_last", 64'(out_last), 0);
        chk("rst_busy", 64'(busy), 0);        chk("rst_done", 64'(done), 0);
        chk("rst_err_short", 64'(err_short), 0); chk("rst_err_over", 64'(err_over), 0);
        chk("rst_in_ready", 64'(in_ready), 0);
    endtask

    task automatic wait_req(input int budget);
        int k = 0;
        while (task_req !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk("task_req_rise", 64'(task_req), 1);
    endtask

    // Pop the model and the DUT together until the model is empty.
    task automatic drain(input bit chk_last);
        int b = 0;
        out_ready = 1'b1;
        while (q.size() > 0 && b < 30) begin
            if (out_valid) begin
                chk("drain_data", 64'(out_data), 64'(q[0]));
                if (chk_last) chk("drain_last", 64'(out_last), 64'((n_pops % N) == N - 1));
                void'(q.pop_front());
                n_pops++;
            end
            step();
            b++;
        end
        out_ready = 1'b0;
        chk("drain_empty", 64'(out_valid), 0);
    endtask

    initial begin
        logic [K-1:0] m1, ysave;
        int beat, g, b;
        rst_n = 1'b0; start = 1'b0; job_mask = '0; cfg_m1 = '0; in_valid = 1'b0;
        in_x = '0; in_y = '0; in_m = '0; task_end = 1'b0; task_grant = 1'b0;
        task_res = '0; out_ready = 1'b0;
        repeat (3) step();
        chk_all_zero();
        rst_n = 1'b1;
        step();

        // Full load with all mask bits and in_valid held high.
        m1 = $urandom; start = 1'b1; job_mask = 3'b111; cfg_m1 = m1;
        step();
        start = 1'b0;
        chk("j1_busy", 64'(busy), 1); chk("j1_in_ready", 64'(in_ready), 1);
        chk("j1_wr_m1", 64'(wr_m1), 64'(m1));
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1; in_x = K'(i + 1); in_y = K'(32'h11 + i); in_m = K'(32'h21 + i);
            step();
            chk("j1_wr_ena", 64'(wr_ena), 7); chk("j1_wr_addr", 64'(wr_addr), 64'(i));
            chk("j1_wr_x", 64'(wr_x), 64'(i + 1)); chk("j1_wr_y", 64'(wr_y), 64'(32'h11 + i));
            chk("j1_wr_m", 64'(wr_m), 64'(32'h21 + i));
        end
        in_valid = 1'b0;
        step();
        chk("j1_lend_ena", 64'(wr_ena), 0); chk("j1_lend_req", 64'(task_req), 0);
        step();
        chk("j1_req", 64'(task_req), 1);

        // Results A..D held back by out_ready=0.
        for (int i = 0; i < N; i++) begin
            task_grant = 1'b1; task_res = K'(32'hA + i); q.push_back(task_res);
            step();
        end
        task_grant = 1'b0;
        chk("j1_out_valid", 64'(out_valid), 1); chk("j1_out_head", 64'(out_data), 64'hA);
        task_end = 1'b1;
        step();
        task_end = 1'b0;
        chk("j1_done", 64'(done), 1); chk("j1_req_low", 64'(task_req), 0);
        chk("j1_busy_low", 64'(busy), 0); chk("j1_err_short", 64'(err_short), 0);
        step();
        chk("j1_done_pulse", 64'(done), 0);

        // Mask 0 job waits for the buffer to drain before requesting.
        start = 1'b1; job_mask = 3'b000; cfg_m1 = 32'hABC;
        step();
        start = 1'b0;
        chk("j2_wr_m1", 64'(wr_m1), 64'hABC); chk("j2_busy", 64'(busy), 1);
        chk("j2_wr_ena", 64'(wr_ena), 0);
        repeat (3) begin
            step();
            chk("j2_req_held", 64'(task_req), 0);
        end
        drain(1'b1);
        wait_req(4);

        // Start while busy is ignored.
        start = 1'b1; job_mask = 3'b111; cfg_m1 = 32'h555;
        step();
        start = 1'b0;
        chk("j2_ign_m1", 64'(wr_m1), 64'hABC); chk("j2_ign_ready", 64'(in_ready), 0);
        chk("j2_ign_req", 64'(task_req), 1);

        // Random grants against random backpressure.
        g = 0; b = 0;
        while ((g < N || q.size() > 0) && b < 80) begin
            chk("j2_valid", 64'(out_valid), 64'(q.size() != 0));
            if (out_valid) begin
                chk("j2_data", 64'(out_data), 64'(q[0]));
                chk("j2_last", 64'(out_last), 64'((n_pops % N) == N - 1));
            end
            out_ready  = 1'($urandom_range(0, 1));
            task_grant = (g < N) && ($urandom_range(0, 1) == 1);
            task_res   = $urandom;
            if (out_valid && out_ready) begin
                void'(q.pop_front());
                n_pops++;
            end
            if (task_grant) begin
                q.push_back(task_res);
                g++;
            end
            step();
            b++;
        end
        task_grant = 1'b0; out_ready = 1'b0;
        chk("j2_all_out", 64'(q.size()), 0);
        task_end = 1'b1;
        step();
        task_end = 1'b0;
        chk("j2_done", 64'(done), 1); chk("j2_err_short", 64'(err_short), 0);

        // Gapped input with only the y bit set.
        start = 1'b1; job_mask = 3'b010; cfg_m1 = $urandom;
        step();
        start = 1'b0;
        chk("j3_in_ready", 64'(in_ready), 1);
        beat = 0;
        for (int c = 0; c < 2 * N; c++) begin
            in_valid = (c % 2 == 0); ysave = $urandom; in_y = ysave; in_x = $urandom;
            step();
            if (c % 2 == 0) begin
                chk("j3_wr_ena", 64'(wr_ena), 2); chk("j3_wr_addr", 64'(wr_addr), 64'(beat));
                chk("j3_wr_y", 64'(wr_y), 64'(ysave));
                beat++;
            end else begin
                chk("j3_gap_ena", 64'(wr_ena), 0);
            end
        end
        in_valid = 1'b0;
        wait_req(4);

        // Short result: only three grants before task_end.
        for (int i = 0; i < 3; i++) begin
            task_grant = 1'b1; task_res = $urandom; q.push_back(task_res);
            step();
        end
        task_grant = 1'b0; task_end = 1'b1;
        step();
        task_end = 1'b0;
        chk("j3_done", 64'(done), 1); chk("j3_err_short", 64'(err_short), 1);
        chk("j3_err_over", 64'(err_over), 0);
        drain(1'b0);

        // Overflow: N+1 grants, only N words kept.
        start = 1'b1; job_mask = 3'b000;
        step();
        start = 1'b0;
        wait_req(4);
        for (int i = 0; i < N + 1; i++) begin
            task_grant = 1'b1; task_res = $urandom;
            if (i < N) q.push_back(task_res);
            step();
        end
        task_grant = 1'b0;
        chk("j4_err_over", 64'(err_over), 1);
        task_end = 1'b1;
        step();
        task_end = 1'b0;
        chk("j4_done", 64'(done), 1); chk("j4_err_short_sticky", 64'(err_short), 1);
        drain(1'b0);
        out_ready = 1'b1;
        repeat (2) step();
        out_ready = 1'b0;
        chk("j4_no_extra", 64'(out_valid), 0);

        // Reset mid-load clears everything, then a new start is accepted.
        start = 1'b1; job_mask = 3'b111; cfg_m1 = $urandom;
        step();
        start = 1'b0; in_valid = 1'b1; in_x = $urandom;
        repeat (2) step();
        rst_n = 1'b0; in_valid = 1'b0;
        step();
        chk_all_zero();
        rst_n = 1'b1;
        step();
        start = 1'b1; job_mask = 3'b000; cfg_m1 = 32'h1234;
        step();
        start = 1'b0;
        chk("r_busy", 64'(busy), 1); chk("r_wr_m1", 64'(wr_m1), 64'h1234);
        wait_req(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
